// File: rtl/bg_pkg.sv
// Shared types and screen constants for the scrolling background renderer.
package bg_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned COORD_W  = 10;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_UP    = 2'd3
   } scroll_dir_t;

   typedef enum logic [1:0] {
      IDLE,
      SCROLL,
      DONE
   } scroll_state_t;

endpackage

// File: rtl/bg_coord_dda.sv
// Per-axis scaling accumulator: tracks floor(n*SRC/SCR) for a screen coordinate n
// that restarts at 0 and advances by one on each step, without multiply/divide.
// Assumes SRC <= SCR, so at most one wrap per step.
module bg_coord_dda #(
   parameter int unsigned SRC = 200,
   parameter int unsigned SCR = 640,
   parameter int unsigned CW  = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          zero,
   input  logic          step,
   output logic [CW-1:0] coord
);

   localparam int unsigned AW = $clog2(SRC + SCR + 1);

   logic [CW-1:0] s_q, s_d;
   logic [AW-1:0] acc_q, acc_d;

   // acc holds the numerator for the next coordinate minus what s already accounts for
   always_comb begin
      s_d   = s_q;
      acc_d = acc_q;
      if (zero) begin
         s_d   = '0;
         acc_d = AW'(SRC);
      end else if (step) begin
         if (acc_q >= AW'(SCR)) begin
            s_d   = s_q + 1'b1;
            acc_d = acc_q - AW'(SCR) + AW'(SRC);
         end else begin
            acc_d = acc_q + AW'(SRC);
         end
      end
   end

   // Hold the scaled coordinate of the pixel just presented
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_q   <= '0;
         acc_q <= '0;
      end else begin
         s_q   <= s_d;
         acc_q <= acc_d;
      end
   end

   assign coord = s_d;

endmodule

// File: rtl/bg_scroll_renderer.sv
// Full-screen background renderer: scales screen pixels onto a multi-room world map in
// ROM, looks colours up through an external palette, and slides between rooms on request.
module bg_scroll_renderer
   import bg_pkg::*;
#(
   parameter int unsigned SRC_W       = 200,
   parameter int unsigned SRC_H       = 200,
   parameter int unsigned SCR_W       = SCREEN_W,
   parameter int unsigned SCR_H       = SCREEN_H,
   parameter int unsigned ROOMS_X     = 2,
   parameter int unsigned ROOMS_Y     = 2,
   parameter int unsigned ADDR_W      = 18,
   parameter int unsigned IDX_W       = 5,
   parameter int unsigned ROM_LAT     = 1,
   parameter int unsigned SCROLL_STEP = 4,
   localparam int unsigned RXW = (ROOMS_X > 1) ? $clog2(ROOMS_X) : 1,
   localparam int unsigned RYW = (ROOMS_Y > 1) ? $clog2(ROOMS_Y) : 1
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              scroll_req,
   input  logic [1:0]        scroll_dir,
   output logic              scroll_busy,
   output logic              scroll_done,
   output logic              scroll_err,
   output logic [RXW-1:0]    room_x,
   output logic [RYW-1:0]    room_y,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue
);

   localparam int unsigned ORG_W      = $clog2(SRC_W * ROOMS_X + SRC_H * ROOMS_Y);
   localparam int unsigned ROW_STRIDE = SRC_W * ROOMS_X;

   logic [COORD_W-1:0] sx, sy, y_prev;
   logic               frame_start;
   logic [ADDR_W-1:0]  addr_d;
   logic [ROM_LAT:0]   blank_pipe;

   scroll_state_t      state;
   logic [ORG_W-1:0]   org_x, org_y, tgt_x, tgt_y, org_x_step, org_y_step;
   logic               axis_y, step_neg;
   logic [RXW-1:0]     nroom_x, req_rx;
   logic [RYW-1:0]     nroom_y, req_ry;
   logic               req_ok;

   bg_coord_dda #(.SRC(SRC_W), .SCR(SCR_W), .CW(COORD_W)) u_dda_x (
      .clk     (vga_clk),
      .reset_n (reset_n),
      .zero    (DrawX == '0),
      .step    (1'b1),
      .coord   (sx)
   );

   bg_coord_dda #(.SRC(SRC_H), .SCR(SCR_H), .CW(COORD_W)) u_dda_y (
      .clk     (vga_clk),
      .reset_n (reset_n),
      .zero    (DrawY == '0),
      .step    (DrawY != y_prev),
      .coord   (sy)
   );

   // Remember the previous row to detect line changes and frame start
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) y_prev <= '0;
      else          y_prev <= DrawY;
   end

   assign frame_start = (DrawY == '0) && (y_prev != '0);

   // Row stride is a constant, so this is a constant multiply
   assign addr_d = (ADDR_W'(org_y) + ADDR_W'(sy)) * ADDR_W'(ROW_STRIDE)
                 + ADDR_W'(org_x) + ADDR_W'(sx);

   // Stage 1 address register and blank delay line aligned to ROM latency
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= '0;
         blank_pipe  <= '0;
      end else begin
         rom_address <= addr_d;
         blank_pipe  <= {blank_pipe[ROM_LAT-1:0], blank};
      end
   end

   assign pal_index = rom_q;

   // Output colour register, forced to black outside active video
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (blank_pipe[ROM_LAT]) begin
         red   <= pal_red;
         green <= pal_green;
         blue  <= pal_blue;
      end else begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end
   end

   // Decode the requested neighbour room and whether it lies on the map
   always_comb begin
      req_rx = room_x;
      req_ry = room_y;
      req_ok = 1'b0;
      unique case (scroll_dir_t'(scroll_dir))
         DIR_RIGHT: begin
            req_ok = (32'(room_x) + 32'd1) < ROOMS_X;
            req_rx = room_x + 1'b1;
         end
         DIR_LEFT: begin
            req_ok = (room_x != '0);
            req_rx = room_x - 1'b1;
         end
         DIR_DOWN: begin
            req_ok = (32'(room_y) + 32'd1) < ROOMS_Y;
            req_ry = room_y + 1'b1;
         end
         DIR_UP: begin
            req_ok = (room_y != '0);
            req_ry = room_y - 1'b1;
         end
      endcase
   end

   assign org_x_step = step_neg ? org_x - ORG_W'(SCROLL_STEP) : org_x + ORG_W'(SCROLL_STEP);
   assign org_y_step = step_neg ? org_y - ORG_W'(SCROLL_STEP) : org_y + ORG_W'(SCROLL_STEP);

   // Room transition FSM; origin only moves on frame start so a frame never tears
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         org_x       <= '0;
         org_y       <= '0;
         tgt_x       <= '0;
         tgt_y       <= '0;
         axis_y      <= 1'b0;
         step_neg    <= 1'b0;
         nroom_x     <= '0;
         nroom_y     <= '0;
         room_x      <= '0;
         room_y      <= '0;
         scroll_busy <= 1'b0;
         scroll_done <= 1'b0;
         scroll_err  <= 1'b0;
      end else begin
         scroll_done <= 1'b0;
         scroll_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (scroll_req) begin
                  if (req_ok) begin
                     tgt_x       <= ORG_W'(req_rx) * ORG_W'(SRC_W);
                     tgt_y       <= ORG_W'(req_ry) * ORG_W'(SRC_H);
                     axis_y      <= scroll_dir[1];
                     step_neg    <= scroll_dir[0];
                     nroom_x     <= req_rx;
                     nroom_y     <= req_ry;
                     scroll_busy <= 1'b1;
                     state       <= SCROLL;
                  end else begin
                     scroll_err <= 1'b1;
                  end
               end
            end
            SCROLL: begin
               if (frame_start) begin
                  if (axis_y) org_y <= org_y_step;
                  else        org_x <= org_x_step;
                  if (axis_y ? (org_y_step == tgt_y) : (org_x_step == tgt_x)) begin
                     room_x      <= nroom_x;
                     room_y      <= nroom_y;
                     scroll_busy <= 1'b0;
                     scroll_done <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Randomised self-checking bench for bg_scroll_renderer against a frame/room level model.
module tb_bg_scroll_renderer;

   localparam int SW = 200;
   localparam int SH = 200;
   localparam int SCW = 640;
   localparam int SCH = 480;
   localparam int STRIDE = 400;
   localparam int NRX = 2;
   localparam int NRY = 2;
   localparam int STEP = 4;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        blank = 1'b0;
   logic        scroll_req = 1'b0;
   logic [1:0]  scroll_dir = '0;
   logic        scroll_busy, scroll_done, scroll_err;
   logic [0:0]  room_x, room_y;
   logic [17:0] rom_address;
   logic [4:0]  rom_q, pal_index;
   logic [3:0]  pal_red, pal_green, pal_blue, red, green, blue;

   int n_vec = 0;
   int n_miss = 0;
   int done_cnt = 0;

   // model state
   int m_ox, m_oy, m_rx, m_ry, m_state, m_nrx, m_nry, m_dx, m_dy, m_prev_y;
   bit e_busy, e_done, e_err;
   int h_addr[3];
   logic [11:0] h_col[3];
   bit h_v[3];

   always #5 vga_clk = ~vga_clk;

   function automatic logic [4:0] rom_fn(input logic [17:0] a);
      return a[4:0] ^ a[9:5] ^ a[14:10];
   endfunction

   function automatic logic [3:0] pr(input logic [4:0] i);
      return i[3:0];
   endfunction
   function automatic logic [3:0] pg(input logic [4:0] i);
      return {i[4], i[2:0]} ^ 4'h9;
   endfunction
   function automatic logic [3:0] pb(input logic [4:0] i);
      return ~i[4:1];
   endfunction

   // external ROM (one cycle) and palette
   always @(posedge vga_clk) rom_q <= rom_fn(rom_address);
   assign pal_red   = pr(pal_index);
   assign pal_green = pg(pal_index);
   assign pal_blue  = pb(pal_index);

   always @(negedge vga_clk) if (scroll_done) done_cnt++;

   bg_scroll_renderer dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .blank       (blank),
      .scroll_req  (scroll_req),
      .scroll_dir  (scroll_dir),
      .scroll_busy (scroll_busy),
      .scroll_done (scroll_done),
      .scroll_err  (scroll_err),
      .room_x      (room_x),
      .room_y      (room_y),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .pal_index   (pal_index),
      .pal_red     (pal_red),
      .pal_green   (pal_green),
      .pal_blue    (pal_blue),
      .red         (red),
      .green       (green),
      .blue        (blue)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_model();
      m_ox = 0; m_oy = 0; m_rx = 0; m_ry = 0; m_state = 0;
      m_nrx = 0; m_nry = 0; m_dx = 0; m_dy = 0; m_prev_y = 0;
      e_busy = 0; e_done = 0; e_err = 0;
      for (int i = 0; i < 3; i++) h_v[i] = 0;
   endtask

   // One pixel clock: check what the DUT shows now, then present the next pixel
   task automatic tick(input int x, input int y, input bit b, input bit req, input int dir);
      int addr, trx, tdy;
      bit fs;
      logic [1:0] d2;
      @(negedge vga_clk);
      if (h_v[0]) check_eq("rom_address", 32'(rom_address), 32'(h_addr[0]));
      if (h_v[2]) check_eq("rgb", 32'({red, green, blue}), 32'(h_col[2]));
      check_eq("scroll_busy", 32'(scroll_busy), 32'(e_busy));
      check_eq("scroll_done", 32'(scroll_done), 32'(e_done));
      check_eq("scroll_err", 32'(scroll_err), 32'(e_err));
      check_eq("room_x", 32'(room_x), 32'(m_rx));
      check_eq("room_y", 32'(room_y), 32'(m_ry));

      d2 = dir[1:0];
      DrawX = 10'(x); DrawY = 10'(y); blank = b; scroll_req = req; scroll_dir = d2;

      fs = (y == 0) && (m_prev_y != 0);
      m_prev_y = y;
      addr = (m_oy + y * SH / SCH) * STRIDE + m_ox + x * SW / SCW;
      h_addr[2] = h_addr[1]; h_col[2] = h_col[1]; h_v[2] = h_v[1];
      h_addr[1] = h_addr[0]; h_col[1] = h_col[0]; h_v[1] = h_v[0];
      h_addr[0] = addr;
      h_col[0] = b ? {pr(rom_fn(18'(addr))), pg(rom_fn(18'(addr))), pb(rom_fn(18'(addr)))}
                   : 12'h000;
      h_v[0] = 1;

      e_done = 0;
      e_err = 0;
      if (m_state == 0) begin
         if (req) begin
            trx = m_rx; tdy = m_ry;
            case (dir)
               0: trx++;
               1: trx--;
               2: tdy++;
               default: tdy--;
            endcase
            if (trx < 0 || trx >= NRX || tdy < 0 || tdy >= NRY) begin
               e_err = 1;
            end else begin
               m_nrx = trx; m_nry = tdy;
               m_dx = (trx - m_rx) * STEP; m_dy = (tdy - m_ry) * STEP;
               m_state = 1; e_busy = 1;
            end
         end
      end else if (m_state == 1) begin
         if (fs) begin
            m_ox += m_dx; m_oy += m_dy;
            if (m_ox == m_nrx * SW && m_oy == m_nry * SH) begin
               m_rx = m_nrx; m_ry = m_nry;
               m_state = 2; e_busy = 0; e_done = 1;
            end
         end
      end else begin
         m_state = 0;
      end
   endtask

   task automatic hard_reset();
      @(negedge vga_clk);
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst_rgb", 32'({red, green, blue}), 32'd0);
      check_eq("rst_rom_address", 32'(rom_address), 32'd0);
      check_eq("rst_busy", 32'(scroll_busy), 32'd0);
      check_eq("rst_done", 32'(scroll_done), 32'd0);
      check_eq("rst_err", 32'(scroll_err), 32'd0);
      check_eq("rst_room", 32'({room_x, room_y}), 32'd0);
      DrawX = '0; DrawY = '0; blank = 1'b0; scroll_req = 1'b0; scroll_dir = '0;
      clear_model();
      repeat (2) @(negedge vga_clk);
      reset_n = 1'b1;
   endtask

   task automatic line(input int y, input int n, input bit rnd_blank);
      for (int x = 0; x < n; x++)
         tick(x, y, rnd_blank ? 1'($urandom_range(0, 1)) : 1'(x < SCW), 0, 0);
   endtask

   task automatic quick_frame();
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0);
   endtask

   task automatic full_frame(input int wpl);
      for (int y = 0; y < SCH; y++) line(y, wpl, 1);
      tick(0, 0, 1, 0, 0);
   endtask

   initial begin
      int dir;
      clear_model();
      hard_reset();

      // static frame in room (0,0), full-width rows at top and bottom
      line(0, 800, 0);
      for (int y = 1; y < SCH - 1; y++) line(y, 4, 1);
      line(SCH - 1, SCW, 1);
      tick(0, 0, 1, 0, 0);

      // scroll right from (0,0), with an ignored request and one full frame mid-scroll
      done_cnt = 0;
      tick(0, 1, 0, 1, 0);
      for (int f = 0; f < 52; f++) begin
         quick_frame();
         if (f == 10) tick(0, 1, 0, 1, 2);
         if (f == 20) full_frame(2);
      end
      check_eq("done_count", 32'(done_cnt), 32'd1);
      check_eq("room_x_after", 32'(room_x), 32'd1);

      // off-map requests from (1,0)
      tick(0, 1, 0, 1, 0);
      tick(0, 1, 0, 0, 0);
      tick(0, 1, 0, 1, 3);
      tick(0, 1, 0, 0, 0);
      quick_frame();

      // random directions
      repeat (4) begin
         dir = int'($urandom_range(0, 3));
         tick(0, 1, 0, 1, dir);
         for (int f = 0; f < 55; f++) quick_frame();
      end

      // request on the same cycle as a frame start
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 1, 1, int'($urandom_range(0, 3)));
      for (int f = 0; f < 55; f++) quick_frame();

      // reset in the middle of a transition
      dir = (m_rx == 0) ? 0 : 1;
      tick(0, 1, 0, 1, dir);
      for (int f = 0; f < 10; f++) quick_frame();
      hard_reset();
      tick(0, 0, 1, 0, 0);
      quick_frame();
      tick(0, 1, 0, 1, 3);
      tick(0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bg_scroll_renderer.md
Name: bg_scroll_renderer

Overview:
- Parametrised full-screen background renderer for the VGA path.
- Maps each screen pixel (DrawX, DrawY) onto a multi-room world map held in an external ROM, and looks up the colour through an external palette.
- Uses incremental scaling counters instead of multiply/divide, with blank-aligned pipelining.
- Adds a per-frame room-transition scroll state machine. The game FSM requests a scroll in a direction; the view slides one room over several frames, then reports done.

Parameters:
- SRC_W, 200: room width in source pixels
- SRC_H, 200: room height in source pixels
- SCR_W, 640: active screen width
- SCR_H, 480: active screen height
- ROOMS_X, 2: rooms across the world map
- ROOMS_Y, 2: rooms down the world map
- ADDR_W, 18: ROM address width; must be ≥ clog2(SRC_W*ROOMS_X*SRC_H*ROOMS_Y)
- IDX_W, 5: palette index width
- ROM_LAT, 1: ROM read latency in cycles
- SCROLL_STEP, 4: source pixels moved per frame; must divide SRC_W and SRC_H

Ports:
- vga_clk, in, 1: pixel clock; DrawX advances by 1 per clock in active video
- reset_n, in, 1: asynchronous, active-low reset
- DrawX, in, 10: current pixel column
- DrawY, in, 10: current pixel row
- blank, in, 1: 1 = active video
- scroll_req, in, 1: 1-cycle request pulse
- scroll_dir, in, 2: 0 right, 1 left, 2 down, 3 up
- scroll_busy, out, 1: transition in progress
- scroll_done, out, 1: 1-cycle pulse when a transition completes
- scroll_err, out, 1: 1-cycle pulse when a request is rejected
- room_x, out, clog2(ROOMS_X): current room column
- room_y, out, clog2(ROOMS_Y): current room row
- rom_address, out, ADDR_W: registered ROM address
- rom_q, in, IDX_W: ROM data, valid ROM_LAT cycles after rom_address
- pal_index, out, IDX_W: equals rom_q (combinational)
- pal_red, pal_green, pal_blue, in, 4 each: combinational palette result
- red, green, blue, out, 4 each: registered pixel colour

Behaviour:
- Reset values:
  - red, green, blue = 0
  - rom_address = 0
  - scroll_busy, scroll_done, scroll_err = 0
  - room_x, room_y = 0; origin (org_x, org_y) = (0, 0)
  - FSM = IDLE; all counters and pipeline valid bits = 0
- Reset mid-scroll aborts the transition and returns the view to room (0,0).
- Horizontal scaling (DDA):
  - On a pixel with DrawX==0: sx = 0, accx = SRC_W.
  - Each following clock: accx += SRC_W; while accx ≥ SCR_W, subtract SCR_W and increment sx.
  - Result must equal floor(DrawX*SRC_W/SCR_W) for every DrawX < SCR_W.
- Vertical scaling: the same scheme on sy/accy, stepped once per DrawY change, reset when DrawY==0.
- Frame start: an internal 1-cycle pulse when DrawY changes from nonzero to 0.
- Address: rom_address = (org_y+sy)*(SRC_W*ROOMS_X) + (org_x+sx), registered in stage 1.
  - The row stride is a constant, so its product is a constant multiply (shift-add acceptable).
- Pipeline: total latency L = ROM_LAT+2 from DrawX/DrawY/blank to red/green/blue (3 at default).
  - blank is delayed by L-1 cycles.
  - Output register loads the palette colour when the delayed blank = 1, else 0.
- Scroll FSM:
  - IDLE:
    - On scroll_req, compute the target room.
    - If the target is outside 0..ROOMS_X-1 / 0..ROOMS_Y-1, pulse scroll_err next cycle and stay IDLE.
    - Otherwise latch target_x = target room × SRC_W (target_y likewise with SRC_H) and go to SCROLL; scroll_busy = 1.
  - SCROLL:
    - On each frame start only, move org by ±SCROLL_STEP along the latched axis.
    - When org equals the target, update room_x/room_y, go to DONE.
    - scroll_req is ignored while in this state.
  - DONE: one cycle; scroll_done = 1, scroll_busy = 0, then IDLE.
  - Origin never changes mid-frame, so there is no tearing.
- Simultaneous scroll_req and frame start in IDLE: accept the request; the first step happens on the next frame start.

Decomposition:
- Shared package bg_pkg:
  - scroll_dir_t enum (DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP)
  - scroll_state_t enum (IDLE, SCROLL, DONE)
  - screen constants 640/480
- One sub-module, bg_coord_dda: per-axis scaling accumulator (instantiated twice, for X and Y).

Test Plan:
- Reset release, static frame, room (0,0):
  - DrawX = 0, 3, 4, 639 → rom_address = sx 0, 0, 1, 199 (DrawY=0).
  - DrawY = 479 → sy = 199, rom_address = 199*400+199 = 79799.
- Latency: one active pixel with a known rom_q → red/green/blue = palette value exactly 3 clocks later; blank = 0 → 0.
- scroll_req, dir=0, from (0,0):
  - busy rises.
  - org_x = 4, 8, … on successive frame starts.
  - After 50 frames: org_x = 200, room_x = 1, scroll_done pulses exactly once.
- From room (1,0), dir=0 → scroll_err pulse, no origin change; dir=3 from (0,0) → scroll_err.
- scroll_req during SCROLL ignored; reset_n low mid-scroll → org (0,0), busy 0, outputs 0 asynchronously.
- Mid-frame check: during SCROLL, org sampled at DrawY=240 is constant across the frame.
